// File: rtl/fb_write_sched.sv
// Frame-buffer write scheduler: takes pixels from a UART or camera source and
// feeds them one word at a time to the SDRAM write FIFO, with frame framing.
module fb_write_sched #(
  parameter int MAX_PIX  = 307200,
  parameter int LOAD_CYC = 4,
  parameter int CNT_W    = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             src_sel,
  input  logic [7:0]       uart_data,
  input  logic             uart_valid,
  input  logic [15:0]      cam_data,
  input  logic             cam_valid,
  input  logic             wr_ready,
  output logic [15:0]      wr_data,
  output logic             wr_en,
  output logic             wr_load,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             ovf
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_LOAD  | wr_load held high for LOAD_CYC cycles, counter cleared
  // S_STREAM| pixels flow through the 1-entry holding register
  // S_DONE  | one-cycle frame_done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PIX);
  localparam logic [LW-1:0]    LOAD_INIT = LW'(LOAD_CYC - 1);

  if (CNT_W < $clog2(MAX_PIX + 1)) begin : g_bad_cnt_w
    $error("fb_write_sched: CNT_W too small for MAX_PIX");
  end

  state_t            r_state;
  logic [LW-1:0]     r_load_cnt;
  logic              r_sel;
  logic              r_hold_v;
  logic [15:0]       r_hold_d;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic              r_ovf;
  logic              r_wr_load;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_strobe;
  logic [15:0]       w_din;
  logic              w_wr_en;
  logic              w_last;

  assign w_strobe = r_sel ? cam_valid : uart_valid;
  assign w_din    = r_sel ? cam_data : {8'h00, uart_data};
  // hold_v is only ever set in STREAM and is cleared on leaving it
  assign w_wr_en  = r_hold_v & wr_ready;
  assign w_last   = w_wr_en && (r_pix_cnt == MAX_CNT - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_load_cnt   <= '0;
      r_sel        <= 1'b0;
      r_hold_v     <= 1'b0;
      r_hold_d     <= '0;
      r_pix_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_wr_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_sel      <= src_sel;
            r_load_cnt <= LOAD_INIT;
            r_pix_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_wr_load  <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state      <= S_DONE;
            r_wr_load    <= 1'b0;
            r_frame_done <= 1'b1;
          end else if (r_load_cnt == '0) begin
            r_state   <= S_STREAM;
            r_wr_load <= 1'b0;
          end else begin
            r_load_cnt <= r_load_cnt - 1'b1;
          end
        end
        S_STREAM: begin
          if (w_wr_en && (r_pix_cnt != MAX_CNT))
            r_pix_cnt <= r_pix_cnt + 1'b1;
          // a slot is free if empty or emptying this cycle
          if (w_strobe && (!r_hold_v || wr_ready)) begin
            r_hold_v <= 1'b1;
            r_hold_d <= w_din;
          end else if (w_strobe) begin
            r_ovf <= 1'b1;
          end else if (w_wr_en) begin
            r_hold_v <= 1'b0;
          end
          if (abort || w_last) begin
            r_state      <= S_DONE;
            r_hold_v     <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = w_wr_en;
  assign wr_data    = r_hold_d;
  assign wr_load    = r_wr_load;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign pix_cnt    = r_pix_cnt;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched: directed frames plus random traffic against a
// cycle-level reference model; a second instance checks long-frame saturation.
module tb_fb_write_sched;
  localparam int MAXP = 4;
  localparam int LC   = 4;
  localparam int CW   = 3;
  localparam int SMAX = 37;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 0, abort = 0, src_sel = 0;
  logic [7:0]  uart_data = 0;
  logic        uart_valid = 0;
  logic [15:0] cam_data = 0;
  logic        cam_valid = 0, wr_ready = 1;
  logic [15:0] wr_data;
  logic        wr_en, wr_load, busy, frame_done, ovf;
  logic [CW-1:0] pix_cnt;

  logic        s_start = 0, s_cam_valid = 0, s_wr_ready = 1;
  logic [15:0] s_cam_data = 0;
  logic [15:0] s_wr_data;
  logic        s_wr_en, s_wr_load, s_busy, s_frame_done, s_ovf;
  logic [5:0]  s_pix_cnt;

  always #10 clk = ~clk;

  fb_write_sched #(.MAX_PIX(MAXP), .LOAD_CYC(LC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .src_sel(src_sel),
    .uart_data(uart_data), .uart_valid(uart_valid), .cam_data(cam_data),
    .cam_valid(cam_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_en(wr_en),
    .wr_load(wr_load), .busy(busy), .frame_done(frame_done), .pix_cnt(pix_cnt),
    .ovf(ovf));

  fb_write_sched #(.MAX_PIX(SMAX), .LOAD_CYC(2), .CNT_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .src_sel(1'b1),
    .uart_data(8'h00), .uart_valid(1'b0), .cam_data(s_cam_data),
    .cam_valid(s_cam_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data),
    .wr_en(s_wr_en), .wr_load(s_wr_load), .busy(s_busy), .frame_done(s_frame_done),
    .pix_cnt(s_pix_cnt), .ovf(s_ovf));

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame phase, load cycles left, 1-deep pending queue
  int          m_phase;      // 0 idle, 1 load, 2 stream, 3 done
  int          m_load_left;
  int          m_cnt;
  bit          m_ovf;
  bit          m_sel;
  logic [15:0] m_q[$];
  int          n_wr, n_done, n_load;

  task automatic model_reset();
    m_phase = 0; m_load_left = 0; m_cnt = 0; m_ovf = 0; m_sel = 0;
    m_q.delete();
  endtask

  // one clock cycle: compare at negedge, advance model, return at posedge+1
  task automatic step();
    bit          ew, stb;
    logic [15:0] din;
    @(negedge clk);
    ew = (m_phase == 2) && (m_q.size() > 0) && wr_ready;
    check_val("wr_en", wr_en, ew);
    check_val("busy", busy, m_phase != 0);
    check_val("wr_load", wr_load, m_phase == 1);
    check_val("frame_done", frame_done, m_phase == 3);
    check_val("pix_cnt", pix_cnt, m_cnt);
    check_val("ovf", ovf, m_ovf);
    if (ew) check_val("wr_data", wr_data, m_q[0]);
    if (wr_en) n_wr++;
    if (frame_done) n_done++;
    if (wr_load) n_load++;
    stb = m_sel ? cam_valid : uart_valid;
    din = m_sel ? cam_data : {8'h00, uart_data};
    case (m_phase)
      0: if (start) begin
           m_phase = 1; m_load_left = LC; m_sel = src_sel; m_cnt = 0; m_ovf = 0;
         end
      1: if (abort) m_phase = 3;
         else begin
           m_load_left--;
           if (m_load_left == 0) m_phase = 2;
         end
      2: begin
           if (ew) begin void'(m_q.pop_front()); m_cnt++; end
           if (stb) begin
             if (m_q.size() == 0) m_q.push_back(din);
             else m_ovf = 1;
           end
           if (abort || (ew && m_cnt == MAXP)) begin m_phase = 3; m_q.delete(); end
         end
      default: m_phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic begin_frame(input bit sel);
    n_wr = 0; n_done = 0; n_load = 0;
    start = 1; src_sel = sel;
    step();
    start = 0;
    repeat (LC) step();
  endtask

  task automatic uart_px(input logic [7:0] d);
    uart_valid = 1; uart_data = d; step(); uart_valid = 0;
  endtask

  task automatic cam_px(input logic [15:0] d);
    cam_valid = 1; cam_data = d; step(); cam_valid = 0;
  endtask

  task automatic settle_idle(input int limit);
    int k = 0;
    while (m_phase != 0 && k < limit) begin step(); k++; end
    step();
    check_val("reach_idle", busy, 1'b0);
  endtask

  initial begin
    model_reset();
    n_wr = 0; n_done = 0; n_load = 0;
    #25; rst_n = 1;
    @(posedge clk); #1;
    step();
    check_val("rst_wr_data", wr_data, 16'h0);

    // four UART bytes complete a frame
    begin_frame(0);
    check_val("load_len", n_load, LC);
    uart_px(8'h11); uart_px(8'h22); uart_px(8'h33); uart_px(8'h44);
    settle_idle(10);
    check_val("uart_writes", n_wr, 4);
    check_val("uart_done_pulses", n_done, 1);
    check_val("uart_pix_cnt", pix_cnt, 4);

    // camera words back-to-back
    begin_frame(1);
    cam_px(16'hABCD); cam_px(16'h1234);
    step();
    check_val("cam_b2b_writes", n_wr, 2);
    check_val("cam_ovf", ovf, 1'b0);
    abort = 1; step(); abort = 0;
    settle_idle(5);

    // overflow while the FIFO is stalled
    begin_frame(0);
    wr_ready = 0;
    uart_px(8'h01); uart_px(8'h02); uart_px(8'h03);
    wr_ready = 1;
    repeat (3) step();
    check_val("ovf_writes", n_wr, 1);
    check_val("ovf_flag", ovf, 1'b1);
    check_val("ovf_pix_cnt", pix_cnt, 1);
    abort = 1; step(); abort = 0;
    settle_idle(5);
    check_val("ovf_sticky_idle", ovf, 1'b1);

    // abort after two writes
    begin_frame(0);
    uart_px(8'h5A); uart_px(8'hA5); step();
    abort = 1; step(); abort = 0;
    check_val("abort_done", frame_done, 1'b1);
    n_wr = 0;
    uart_px(8'h77); step(); step();
    check_val("abort_pix_cnt", pix_cnt, 2);
    check_val("abort_no_wr", n_wr, 0);
    check_val("abort_done_pulses", n_done, 1);
    check_val("ovf_cleared", ovf, 1'b0);

    // asynchronous reset mid-stream
    begin_frame(1);
    cam_px(16'h0F0F); cam_px(16'hF0F0);
    #4 rst_n = 0;
    #1;
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_pix_cnt", pix_cnt, 0);
    check_val("arst_wr_en", wr_en, 1'b0);
    check_val("arst_wr_data", wr_data, 16'h0);
    #7 rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    n_done = 0;
    repeat (4) step();
    check_val("arst_no_done", n_done, 0);
    begin_frame(0);
    check_val("arst_reload_len", n_load, LC);
    uart_px(8'h01); uart_px(8'h02); uart_px(8'h03); uart_px(8'h04);
    settle_idle(10);

    // random traffic, including start/src_sel noise and aborts
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      src_sel    = $urandom_range(0, 1);
      abort      = ($urandom_range(0, 63) == 0);
      uart_valid = $urandom_range(0, 1);
      uart_data  = 8'($urandom);
      cam_valid  = $urandom_range(0, 1);
      cam_data   = 16'($urandom);
      wr_ready   = ($urandom_range(0, 9) < 7);
      step();
    end
    start = 0; uart_valid = 0; cam_valid = 0; wr_ready = 1;
    abort = 1; step(); abort = 0;
    settle_idle(5);

    // long frame on the second instance: exact write count, no wrap
    begin
      int sw = 0, sd = 0;
      s_start = 1; s_cam_valid = 1; s_wr_ready = 1;
      @(posedge clk); #1;
      s_start = 0;
      for (int c = 0; c < 120; c++) begin
        s_cam_data = 16'($urandom);
        @(negedge clk);
        if (s_wr_en) sw++;
        if (s_frame_done) sd++;
        @(posedge clk); #1;
      end
      s_cam_valid = 0;
      check_val("sat_writes", sw, SMAX);
      check_val("sat_pix_cnt", s_pix_cnt, SMAX);
      check_val("sat_done_pulses", sd, 1);
      check_val("sat_busy", s_busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
